// File: rtl/spark_servo_pwm_gen_pkg.sv
// Shared types, default timing constants and the ratio-to-pulse-width mapping
// for the Spark servo PWM generator.
package spark_pwm_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARM      = 2'd1,
    RUN      = 2'd2
  } state_t;

  localparam int unsigned CLK_TICK_DIV = 27;    // 27 MHz clock -> 1 us tick
  localparam int unsigned NEUTRAL_US   = 1500;
  localparam int unsigned SPAN_DEF_US  = 500;
  localparam int unsigned FRAME_US     = 5000;  // 200 Hz frame
  localparam int unsigned ARM_FRAMES   = 4;

  // Neutral +/- (ratio * span) >> 8, truncating; 255 maps just short of full span.
  function automatic logic [11:0] servo_width(input logic [7:0]  ratio,
                                              input logic        dir,
                                              input int unsigned center,
                                              input int unsigned span);
    logic [17:0] prod;
    logic [11:0] dev;
    prod = 18'(ratio) * 18'(span);
    dev  = 12'(prod[17:8]);
    servo_width = dir ? (12'(center) + dev) : (12'(center) - dev);
  endfunction

endpackage

// File: rtl/spark_servo_pwm_gen_us_tick.sv
// Prescaler producing a one-cycle us_tick every TICK_DIV clocks; clear holds it at phase 0.
module pwm_us_tick
  import spark_pwm_pkg::*;
#(
  parameter int unsigned TICK_DIV = CLK_TICK_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic us_tick
);

  localparam int unsigned   CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign us_tick = !clear && (cnt == LAST);

  always_ff @(posedge clock) begin
    if (reset || clear || us_tick) cnt <= '0;
    else                           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/spark_servo_pwm_gen.sv
// RC-servo pulse generator: takes PID width commands over an update/done handshake,
// arms with neutral frames after enable, then applies commands on frame boundaries.
module spark_servo_pwm_gen
  import spark_pwm_pkg::*;
#(
  parameter int unsigned TICK_DIV    = CLK_TICK_DIV,
  parameter int unsigned PERIOD_US   = FRAME_US,
  parameter int unsigned CENTER_US   = NEUTRAL_US,
  parameter int unsigned SPAN_US     = SPAN_DEF_US,
  parameter int unsigned ARM_PERIODS = ARM_FRAMES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pwm_enable,
  input  logic        pwm_update,
  input  logic [7:0]  pwm_ratio,
  input  logic        pwm_direction,
  output logic        pwm_done,
  output logic        pwm_signal,
  output logic        pwm_armed,
  output logic [11:0] pulse_width_us
);

  localparam logic [11:0] CENTER_W   = 12'(CENTER_US);
  localparam logic [15:0] FRAME_LAST = 16'(PERIOD_US - 1);
  localparam logic [7:0]  ARM_LAST   = 8'(ARM_PERIODS - 1);

  state_t      state, state_next;
  logic [15:0] frame_cnt;
  logic [7:0]  arm_cnt;
  logic [11:0] cmd_width, pending_width, upd_width;
  logic        pending, us_tick, boundary, frame_load;

  pwm_us_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock   (clock),
    .reset   (reset),
    .clear   (state == DISABLED),
    .us_tick (us_tick)
  );

  assign upd_width = servo_width(pwm_ratio, pwm_direction, CENTER_US, SPAN_US);
  assign boundary  = us_tick && (frame_cnt == FRAME_LAST);
  // Boundaries that (re)load the frame width: every RUN boundary and the last ARM one.
  assign frame_load = boundary && pwm_enable &&
                      ((state == RUN) || ((state == ARM) && (arm_cnt == ARM_LAST)));
  assign pwm_armed = (state == RUN);

  always_comb begin
    state_next = state;
    unique case (state)
      DISABLED: if (pwm_enable) state_next = ARM;
      ARM: begin
        if (!pwm_enable)                          state_next = DISABLED;
        else if (boundary && arm_cnt == ARM_LAST) state_next = RUN;
      end
      RUN:     if (!pwm_enable) state_next = DISABLED;
      default: state_next = DISABLED;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= DISABLED;
      cmd_width      <= CENTER_W;
      pending_width  <= CENTER_W;
      pending        <= 1'b0;
      frame_cnt      <= '0;
      arm_cnt        <= '0;
      pulse_width_us <= CENTER_W;
      pwm_signal     <= 1'b0;
      pwm_done       <= 1'b0;
    end else begin
      state    <= state_next;
      pwm_done <= 1'b0;
      // Gating on pwm_enable drops the pin in the same cycle the disable is sampled.
      pwm_signal <= (state != DISABLED) && pwm_enable &&
                    (frame_cnt < {4'd0, pulse_width_us});

      if (state == DISABLED)
        frame_cnt <= '0;
      else if (us_tick)
        frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 16'd1;

      if (state == DISABLED) begin
        if (pwm_update) begin
          cmd_width <= upd_width;
          pwm_done  <= 1'b1;
        end
        if (pwm_enable) begin
          arm_cnt        <= '0;
          pulse_width_us <= CENTER_W;
        end
      end else if (!pwm_enable) begin
        if (pending) begin
          cmd_width <= pending_width;
          pwm_done  <= 1'b1;
        end
        pending <= 1'b0;
      end else begin
        if (boundary && state == ARM) arm_cnt <= arm_cnt + 8'd1;
        if (frame_load) begin
          if (pending) begin
            pulse_width_us <= pending_width;
            cmd_width      <= pending_width;
            pwm_done       <= 1'b1;
          end else begin
            pulse_width_us <= cmd_width;
          end
        end
        // An update coinciding with a load is held for the following boundary.
        if (pwm_update) begin
          pending_width <= upd_width;
          pending       <= 1'b1;
        end else if (frame_load) begin
          pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spark_servo_pwm_gen.sv
// Scoreboard bench: stimulus predicts pulses, acks and arming edges by clock edge;
// a monitor compares what the DUT produces against those queues.
module tb_spark_servo_pwm_gen;

  localparam int T = 2;    // clocks per us
  localparam int P = 128;  // frame length in us
  localparam int C = 60;   // neutral width
  localparam int S = 40;   // span
  localparam int A = 4;    // arming frames
  localparam int F = T * P;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pwm_enable = 1'b0;
  logic        pwm_update = 1'b0;
  logic [7:0]  pwm_ratio = '0;
  logic        pwm_direction = 1'b0;
  logic        pwm_done, pwm_signal, pwm_armed;
  logic [11:0] pulse_width_us;

  spark_servo_pwm_gen #(
    .TICK_DIV(T), .PERIOD_US(P), .CENTER_US(C), .SPAN_US(S), .ARM_PERIODS(A)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .pwm_enable     (pwm_enable),
    .pwm_update     (pwm_update),
    .pwm_ratio      (pwm_ratio),
    .pwm_direction  (pwm_direction),
    .pwm_done       (pwm_done),
    .pwm_signal     (pwm_signal),
    .pwm_armed      (pwm_armed),
    .pulse_width_us (pulse_width_us)
  );

  always #5 clock = ~clock;

  longint cyc = 0;  // number of rising edges so far
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {longint start; longint len;} pulse_t;
  typedef struct {longint at; int pw;} done_t;
  typedef struct {longint at; bit lvl;} arm_t;
  typedef struct {int d; logic [7:0] r; bit dir;} upd_t;

  pulse_t exp_pulse[$];
  done_t  exp_done[$];
  arm_t   exp_arm[$];
  upd_t   sched[$];

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;
  int last_val = C;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input longint at);
    vectors++;
    miscompares++;
    $display("FAIL %s: event at edge %0d, none expected", name, at);
  endtask

  function automatic int model_width(input logic [7:0] r, input bit dir);
    int dev;
    dev = (int'(r) * S) / 256;
    return dir ? C + dev : C - dev;
  endfunction

  // Monitor
  bit     sig_q = 1'b0;
  bit     arm_q = 1'b0;
  longint p_start = 0;
  pulse_t pq;
  done_t  dq;
  arm_t   aq;

  always begin
    @(posedge clock);
    #2;
    if (mon_en) begin
      if (pwm_signal && !sig_q) p_start = cyc;
      if (!pwm_signal && sig_q) begin
        if (exp_pulse.size() == 0) unexpected("pulse", p_start);
        else begin
          pq = exp_pulse.pop_front();
          check("pulse_start", p_start, pq.start);
          check("pulse_len", cyc - p_start, pq.len);
        end
      end
      sig_q = pwm_signal;
      if (pwm_done) begin
        if (exp_done.size() == 0) unexpected("done", cyc);
        else begin
          dq = exp_done.pop_front();
          check("done_edge", cyc, dq.at);
          if (dq.pw >= 0) check("done_width", longint'(pulse_width_us), dq.pw);
        end
      end
      if (pwm_armed != arm_q) begin
        if (exp_arm.size() == 0) unexpected("armed", cyc);
        else begin
          aq = exp_arm.pop_front();
          check("armed_edge", cyc, aq.at);
          check("armed_level", longint'(pwm_armed), longint'(aq.lvl));
        end
        arm_q = pwm_armed;
      end
    end
  end

  // One enable episode: optional update while disabled, enable, d_end edges of
  // operation with scheduled/random updates, then disable or reset.
  task automatic run_segment(input bit pre_upd, input logic [7:0] pre_r, input bit pre_dir,
                             input int d_end, input bit by_reset, input int rate);
    longint n_e, n_end, e, st, ln, last_done_at;
    int     d, k, tk, run_w, w, val;
    bit     issue;
    int     tgt[int];
    upd_t   u;
    done_t  de;
    arm_t   ae;
    pulse_t pe;
    last_done_at = -1;
    if (pre_upd) begin
      @(negedge clock);
      pwm_update = 1'b1; pwm_ratio = pre_r; pwm_direction = pre_dir;
      last_val = model_width(pre_r, pre_dir);
      de.at = cyc + 1; de.pw = -1;
      exp_done.push_back(de);
      @(negedge clock);
      pwm_update = 1'b0;
    end
    repeat (3) @(negedge clock);
    pwm_enable = 1'b1;
    n_e = cyc + 1;
    n_end = n_e + d_end;
    run_w = last_val;
    if (A * F < d_end) begin
      ae.at = n_e + A * F; ae.lvl = 1'b1; exp_arm.push_back(ae);
      ae.at = n_end;       ae.lvl = 1'b0; exp_arm.push_back(ae);
    end
    forever begin
      @(negedge clock);
      pwm_update = 1'b0;
      d = int'(cyc + 1 - n_e);
      if (d >= d_end) break;
      if (d % F == 1) begin
        k = (d - 1) / F;
        if (k >= A && tgt.exists(k)) run_w = tgt[k];
        w = (k < A) ? C : run_w;
        st = n_e + longint'(k) * F + 1;
        ln = longint'(w) * T;
        if (n_end - st < ln) ln = n_end - st;
        if (ln > 0) begin
          pe.start = st; pe.len = ln;
          exp_pulse.push_back(pe);
        end
      end
      issue = 1'b0;
      if (sched.size() > 0 && sched[0].d == d) begin
        u = sched.pop_front();
        issue = 1'b1;
      end else if (rate > 0 && $urandom_range(rate - 1) == 0) begin
        u.d = d; u.r = 8'($urandom); u.dir = 1'($urandom_range(1));
        issue = 1'b1;
      end
      if (issue) begin
        pwm_update = 1'b1; pwm_ratio = u.r; pwm_direction = u.dir;
        val = model_width(u.r, u.dir);
        last_val = val;
        tk = d / F + 1;
        if (tk < A) tk = A;
        tgt[tk] = val;
        e = n_e + longint'(tk) * F;
        if (!(by_reset && e >= n_end)) begin
          de.pw = val;
          if (e >= n_end) begin
            e = n_end;
            de.pw = -1;
          end
          de.at = e;
          if (e == last_done_at) void'(exp_done.pop_back());
          exp_done.push_back(de);
          last_done_at = e;
        end
      end
    end
    if (by_reset) begin
      reset = 1'b1; pwm_enable = 1'b0;
      @(posedge clock);
      #2;
      check("reset_signal", longint'(pwm_signal), 0);
      check("reset_done", longint'(pwm_done), 0);
      check("reset_armed", longint'(pwm_armed), 0);
      check("reset_width", longint'(pulse_width_us), C);
      @(negedge clock);
      reset = 1'b0;
      last_val = C;
    end else begin
      pwm_enable = 1'b0;
    end
    repeat (5) @(negedge clock);
  endtask

  function automatic upd_t mk(input int d, input logic [7:0] r, input bit dir);
    upd_t x;
    x.d = d; x.r = r; x.dir = dir;
    return x;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(negedge clock);
    check("init_signal", longint'(pwm_signal), 0);
    check("init_done", longint'(pwm_done), 0);
    check("init_armed", longint'(pwm_armed), 0);
    check("init_width", longint'(pulse_width_us), C);
    reset = 1'b0;
    mon_en = 1'b1;

    // Arming with no commands: neutral throughout, then disable mid-frame.
    run_segment(1'b0, 8'd0, 1'b0, 6 * F + 100, 1'b0, 0);

    // RUN: full-scale forward, a burst of three, a boundary-cycle update,
    // and a command still pending when enable drops.
    sched.push_back(mk(5 * F + 100, 8'd255, 1'b1));
    sched.push_back(mk(6 * F + 30,  8'd10,  1'b1));
    sched.push_back(mk(6 * F + 90,  8'd200, 1'b0));
    sched.push_back(mk(6 * F + 200, 8'd128, 1'b0));
    sched.push_back(mk(7 * F,       8'd64,  1'b0));
    sched.push_back(mk(8 * F + 10,  8'd30,  1'b0));
    run_segment(1'b0, 8'd0, 1'b0, 8 * F + 50, 1'b0, 0);

    // Command while disabled is acked at once and used after arming.
    run_segment(1'b1, 8'd64, 1'b1, 5 * F + 100, 1'b0, 0);

    // Commands during ARM: one ack at the switch to RUN, last value wins.
    sched.push_back(mk(F + 50,     8'd200, 1'b1));
    sched.push_back(mk(2 * F + 10, 8'd30,  1'b0));
    run_segment(1'b0, 8'd0, 1'b0, 5 * F + 44, 1'b0, 0);

    // Disable during ARM with a pending command.
    sched.push_back(mk(F + 10, 8'd100, 1'b1));
    run_segment(1'b0, 8'd0, 1'b0, 2 * F + 5, 1'b0, 0);

    for (int i = 0; i < 3; i++)
      run_segment(1'($urandom_range(1)), 8'($urandom), 1'($urandom_range(1)),
                  int'($urandom_range(6 * F, 10 * F)), 1'b0, 48);

    // Reset asserted mid-pulse in RUN.
    run_segment(1'b0, 8'd0, 1'b0, 6 * F + 20, 1'b1, 40);

    repeat (20) @(negedge clock);
    check("pulses_outstanding", exp_pulse.size(), 0);
    check("acks_outstanding", exp_done.size(), 0);
    check("arm_edges_outstanding", exp_arm.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
